// File: rtl/ram_port_ctrl_pkg.sv
// Shared types and defaults for the registered DMEM port controller.
// Holds the FSM encoding, the wait counter type and the default bus widths.
package ram_port_ctrl_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ADDR_WIDTH = 8;
    localparam int CNT_WIDTH      = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_TURN   = 2'd2
    } state_t;

    typedef logic [CNT_WIDTH-1:0] cnt_t;

    // Saturating decrement: the wait counter parks at zero instead of wrapping.
    function automatic cnt_t cnt_dec(input cnt_t c);
        return (c == '0) ? '0 : cnt_t'(c - cnt_t'(1));
    endfunction

endpackage

// File: rtl/ram_port_ctrl_port_tristate.sv
// Tri-state driver for the DMEM data bus: drives registered data when enabled
// and hands the resolved bus value back to the controller for read capture.
module port_tristate
    import ram_port_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  drive_en,
    input  logic [DATA_WIDTH-1:0] drive_data,
    output logic [DATA_WIDTH-1:0] bus_sample,
    inout  wire  [DATA_WIDTH-1:0] bus
);

    assign bus        = drive_en ? drive_data : {DATA_WIDTH{1'bz}};
    assign bus_sample = bus;

endmodule

// File: rtl/ram_port_ctrl.sv
// Registered DMEM port controller: turns a valid/ready request stream into
// bus accesses with programmable wait states and a post-write turnaround gap.
module ram_port_ctrl
    import ram_port_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int WAIT_STATES = 1,
    parameter int TURNAROUND  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  port_write,
    output logic [ADDR_WIDTH-1:0] port_addr,
    inout  wire  [DATA_WIDTH-1:0] port_value
);

    localparam bit   HAS_TURN  = (TURNAROUND > 0);
    localparam cnt_t WAIT_LOAD = cnt_t'(WAIT_STATES);
    localparam cnt_t TURN_LOAD = HAS_TURN ? cnt_t'(TURNAROUND - 1) : '0;

    state_t                state_q;
    state_t                state_d;
    cnt_t                  cnt_q;
    cnt_t                  cnt_d;
    logic                  acc_write_q;
    logic                  acc_write_d;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] wdata_d;
    logic                  drive_en_q;
    logic                  drive_en_d;
    logic [ADDR_WIDTH-1:0] port_addr_d;
    logic                  port_write_d;
    logic                  rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_d;
    logic [DATA_WIDTH-1:0] bus_sample;

    logic accept;
    logic access_done;
    logic exit_to_turn;

    assign req_ready    = (state_q == ST_IDLE) && !rst;
    assign accept       = req_valid && req_ready;
    assign access_done  = (state_q == ST_ACCESS) && (cnt_q == '0);
    assign exit_to_turn = acc_write_q && HAS_TURN;

    // State register: FSM state, counter, latched request and every bus-facing output.
    always_ff @(posedge clk) begin
        // NOTE: all sequential state uses non-blocking assignments so every register
        // samples its inputs from before the edge.
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            acc_write_q <= 1'b0;
            wdata_q     <= '0;
            drive_en_q  <= 1'b0;
            port_addr   <= '0;
            port_write  <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_write_q <= acc_write_d;
            wdata_q     <= wdata_d;
            drive_en_q  <= drive_en_d;
            port_addr   <= port_addr_d;
            port_write  <= port_write_d;
            rsp_valid   <= rsp_valid_d;
            rsp_rdata   <= rsp_rdata_d;
        end
    end

    // Next-state logic.
    always_comb begin
        // NOTE: defaulting every combinational output before the case keeps
        // unlisted paths from inferring latches.
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (cnt_q == '0) state_d = exit_to_turn ? ST_TURN : ST_IDLE;
            end
            ST_TURN: begin
                if (cnt_q == '0) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output logic: next values of the registered bus pins, counter and response.
    always_comb begin
        cnt_d        = cnt_dec(cnt_q);
        acc_write_d  = acc_write_q;
        wdata_d      = wdata_q;
        port_addr_d  = port_addr;
        port_write_d = 1'b0;
        drive_en_d   = 1'b0;
        rsp_valid_d  = 1'b0;
        rsp_rdata_d  = rsp_rdata;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    cnt_d        = WAIT_LOAD;
                    acc_write_d  = req_write;
                    wdata_d      = req_wdata;
                    port_addr_d  = req_addr;
                    port_write_d = req_write;
                    drive_en_d   = req_write;
                end
            end
            ST_ACCESS: begin
                if (access_done) begin
                    rsp_valid_d = 1'b1;
                    if (!acc_write_q) rsp_rdata_d = bus_sample;
                    if (exit_to_turn) cnt_d = TURN_LOAD;
                end else begin
                    port_write_d = acc_write_q;
                    drive_en_d   = acc_write_q;
                end
            end
            default: begin
            end
        endcase
    end

    port_tristate #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_port_tristate (
        .drive_en  (drive_en_q),
        .drive_data(wdata_q),
        .bus_sample(bus_sample),
        .bus       (port_value)
    );

endmodule

// File: tb/tb_ram_port_ctrl.sv
// Self-checking bench for ram_port_ctrl: directed cases with literal expectations
// plus randomized traffic compared every cycle against a schedule-based model.
module tb_ram_port_ctrl;

    localparam int DW = 8;
    localparam int AW = 8;
    localparam int WS = 2;
    localparam int TA = 2;

    bit            clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_write = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          req_ready;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          port_write;
    logic [AW-1:0] port_addr;
    wire  [DW-1:0] port_value;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ram_port_ctrl #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .WAIT_STATES(WS),
        .TURNAROUND (TA)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .port_write(port_write),
        .port_addr (port_addr),
        .port_value(port_value)
    );

    function automatic logic [7:0] init_val(input logic [7:0] a);
        return a ^ 8'hA0;
    endfunction

    // Memory device on the pins: written by the DUT's strobe, read back when the model says so.
    logic [DW-1:0] dev_mem [256];
    bit            dev_written [256];
    logic [DW-1:0] dev_rdata;
    bit            tb_rd_en = 1'b0;
    bit            tb_probe_en = 1'b0;

    always @(posedge clk) begin
        if (port_write === 1'b1) begin
            dev_mem[port_addr]     <= port_value;
            dev_written[port_addr] <= 1'b1;
        end
    end

    assign dev_rdata  = dev_written[port_addr] ? dev_mem[port_addr] : init_val(port_addr);
    assign port_value = tb_rd_en ? dev_rdata : (tb_probe_en ? 8'h00 : 8'hzz);

    // Reference model: each accepted request is a schedule of cycle numbers.
    int            cyc = 0;
    bit            model_valid = 1'b0;
    int            acc_lo = 1;
    int            acc_hi = 0;
    int            rsp_at = -1;
    int            free_at = 0;
    bit            lat_w = 1'b0;
    logic [DW-1:0] lat_wdata = '0;
    logic [AW-1:0] exp_addr = '0;
    logic [DW-1:0] exp_rdata = '0;
    logic [DW-1:0] pend_rdata = '0;
    logic [DW-1:0] ref_mem [256];

    function automatic bit in_acc(input int c);
        return (c >= acc_lo) && (c <= acc_hi);
    endfunction

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            model_valid = 1'b1;
            acc_lo      = 1;
            acc_hi      = 0;
            rsp_at      = -1;
            free_at     = cyc;
            lat_w       = 1'b0;
            exp_addr    = '0;
            exp_rdata   = '0;
        end else if (model_valid) begin
            if (cyc == rsp_at && !lat_w) exp_rdata = pend_rdata;
            if (req_valid && (cyc - 1) >= free_at) begin
                lat_w     = req_write;
                lat_wdata = req_wdata;
                exp_addr  = req_addr;
                acc_lo    = cyc;
                acc_hi    = cyc + WS;
                rsp_at    = cyc + WS + 1;
                free_at   = rsp_at + (req_write ? TA : 0);
                if (req_write) ref_mem[req_addr] = req_wdata;
                else pend_rdata = ref_mem[req_addr];
            end
        end
    end

    // Bench-side bus drivers change well away from both clock edges.
    always @(posedge clk) begin
        #2;
        tb_rd_en    = model_valid && in_acc(cyc) && !lat_w;
        tb_probe_en = !(model_valid && in_acc(cyc));
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin : cmp
        bit acc;
        if (model_valid) begin
            acc = in_acc(cyc);
            check("req_ready", 32'(req_ready), 32'((cyc >= free_at) && !rst));
            check("port_write", 32'(port_write), 32'(acc && lat_w));
            check("port_addr", 32'(port_addr), 32'(exp_addr));
            check("rsp_valid", 32'(rsp_valid), 32'(cyc == rsp_at));
            check("rsp_rdata", 32'(rsp_rdata), 32'(exp_rdata));
            if (acc && lat_w) check("bus_wdata", 32'(port_value), 32'(lat_wdata));
            else if (!acc) check("bus_released", 32'(port_value), 32'h0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int  rst_cnt = 0;
    bit  ready_now;

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(8'(i));

        // Reset state.
        repeat (2) step();
        rst = 1'b0;
        @(negedge clk);
        check("lit_reset_ready", 32'(req_ready), 32'h1);
        check("lit_reset_addr", 32'(port_addr), 32'h0);
        check("lit_reset_rdata", 32'(rsp_rdata), 32'h0);
        check("lit_reset_write", 32'(port_write), 32'h0);

        // Read of 0x05; the pending address churns while the controller is busy.
        step();
        req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h05; req_wdata = 8'h00;
        step();
        req_addr = 8'h33;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k <= 3) begin
                check("lit_rd_addr", 32'(port_addr), 32'h05);
                check("lit_rd_write", 32'(port_write), 32'h0);
                check("lit_rd_ready", 32'(req_ready), 32'h0);
                check("lit_rd_rspv", 32'(rsp_valid), 32'h0);
            end else begin
                check("lit_rd_rspv", 32'(rsp_valid), 32'h1);
                check("lit_rd_data", 32'(rsp_rdata), 32'hA5);
                check("lit_rd_ready", 32'(req_ready), 32'h1);
                req_valid = 1'b0;
            end
        end

        // Write 0x3C to 0x10: three drive cycles, two released cycles, then idle.
        step();
        req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h10; req_wdata = 8'h3C;
        step();
        req_valid = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k <= 3) begin
                check("lit_wr_strobe", 32'(port_write), 32'h1);
                check("lit_wr_bus", 32'(port_value), 32'h3C);
            end else if (k <= 5) begin
                check("lit_turn_strobe", 32'(port_write), 32'h0);
                check("lit_turn_bus", 32'(port_value), 32'h0);
                check("lit_turn_ready", 32'(req_ready), 32'h0);
                check("lit_turn_rspv", 32'(rsp_valid), 32'(k == 4));
            end else begin
                check("lit_turn_done", 32'(req_ready), 32'h1);
            end
        end

        // Read back 0x10.
        step();
        req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h10;
        step();
        req_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("lit_rb_rspv", 32'(rsp_valid), 32'h1);
        check("lit_rb_data", 32'(rsp_rdata), 32'h3C);

        // Reset for two cycles in the middle of a write.
        step();
        req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h20; req_wdata = 8'h5A;
        step();
        req_valid = 1'b0;
        @(negedge clk);
        check("lit_abort_pre", 32'(port_write), 32'h1);
        step();
        rst = 1'b1;
        step();
        @(negedge clk);
        check("lit_abort_strobe", 32'(port_write), 32'h0);
        check("lit_abort_bus", 32'(port_value), 32'h0);
        check("lit_abort_addr", 32'(port_addr), 32'h0);
        check("lit_abort_rspv", 32'(rsp_valid), 32'h0);
        step();
        rst = 1'b0;
        @(negedge clk);
        check("lit_abort_ready", 32'(req_ready), 32'h1);
        check("lit_abort_rspv2", 32'(rsp_valid), 32'h0);

        // Randomized traffic with stalls, churn on pending requests and sporadic resets.
        for (int i = 0; i < 2000; i++) begin
            step();
            if (rst_cnt > 0) begin
                rst = 1'b1;
                rst_cnt--;
            end else begin
                rst = 1'b0;
                if ($urandom_range(0, 149) == 0) rst_cnt = 2;
            end
            ready_now = (cyc >= free_at) && !rst;
            if (req_valid && !ready_now) begin
                if ($urandom_range(0, 7) == 0) begin
                    req_valid = 1'b0;
                end else begin
                    req_write = 1'($urandom_range(0, 1));
                    req_addr  = 8'($urandom_range(0, 15));
                    req_wdata = 8'($urandom);
                end
            end else if (!req_valid && $urandom_range(0, 2) != 0) begin
                req_valid = 1'b1;
                req_write = 1'($urandom_range(0, 1));
                req_addr  = 8'($urandom_range(0, 15));
                req_wdata = 8'($urandom);
            end
        end

        rst = 1'b0;
        req_valid = 1'b0;
        repeat (12) step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
